// File: rtl/cw_decoder_ctrl.sv
// Sequencing controller for the constant-weight decoder: gates host codewords into
// the input FIFO, starts the decoder after a prefill, and deserializes its bit stream.
module cw_decoder_ctrl #(
  parameter int CW_W    = 18,
  parameter int MSG_W   = 9,
  parameter int NUM_CW  = 10,
  parameter int PREFILL = 2,
  parameter int TO_CYC  = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             host_valid,
  input  logic [CW_W-1:0]  host_cw,
  output logic             host_ready,
  output logic             fifo_wr_en,
  output logic [CW_W-1:0]  fifo_din,
  input  logic             fifo_full,
  output logic             fifo_flush,
  output logic             dec_start,
  input  logic             dec_bin_msg,
  input  logic             dec_msg_rdy,
  input  logic             dec_msg_done,
  output logic             out_valid,
  output logic [MSG_W-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic [1:0]       err
);

  // The word counter has one spare code so a runaway decoder saturates instead of
  // wrapping back onto NUM_CW.
  localparam int CNT_W = $clog2(NUM_CW + 2);
  localparam int BIT_W = $clog2(MSG_W + 1);
  localparam int TO_W  = $clog2(TO_CYC + 1);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_COUNT   = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DONE, S_ERR} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cw_in_cnt_q, cw_out_cnt_q;
  logic [BIT_W-1:0] bit_cnt_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic [MSG_W-2:0] shreg_q;
  logic [MSG_W-1:0] out_data_q;
  logic             out_valid_q, dec_start_q, fifo_flush_q, done_q;
  logic [1:0]       err_q;

  logic [CNT_W-1:0] cw_in_cnt_d, final_cnt_d;
  logic [BIT_W-1:0] bit_cnt_d;
  logic [MSG_W-1:0] word_d;
  logic             bit_take, word_done, to_hit;

  assign host_ready = ((state_q == S_LOAD) || (state_q == S_RUN)) && !fifo_full &&
                      (cw_in_cnt_q < CNT_W'(NUM_CW));
  assign fifo_wr_en = host_valid && host_ready;
  assign fifo_din   = host_cw;
  assign busy       = (state_q != S_IDLE);
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign dec_start  = dec_start_q;
  assign fifo_flush = fifo_flush_q;
  assign done       = done_q;
  assign err        = err_q;

  always_comb begin
    cw_in_cnt_d = cw_in_cnt_q + CNT_W'(fifo_wr_en);
    bit_take    = (state_q == S_RUN) && dec_msg_rdy;
    word_done   = bit_take && (bit_cnt_q == BIT_W'(MSG_W - 1));
    word_d      = {shreg_q, dec_bin_msg};
    bit_cnt_d   = word_done ? '0 : bit_cnt_q + BIT_W'(bit_take);
    final_cnt_d = cw_out_cnt_q;
    if (word_done && (cw_out_cnt_q != CNT_W'(NUM_CW + 1)))
      final_cnt_d = cw_out_cnt_q + CNT_W'(1);
    to_hit      = (to_cnt_q == TO_W'(TO_CYC - 1));
  end

  // Controller FSM; every output pulse is registered on the transition that causes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cw_in_cnt_q  <= '0;
      cw_out_cnt_q <= '0;
      bit_cnt_q    <= '0;
      to_cnt_q     <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      dec_start_q  <= 1'b0;
      fifo_flush_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= ERR_NONE;
    end else begin
      dec_start_q  <= 1'b0;
      fifo_flush_q <= 1'b0;
      out_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      if (fifo_wr_en)
        cw_in_cnt_q <= cw_in_cnt_d;

      case (state_q)
        S_IDLE, S_ERR: begin
          if (go) begin
            state_q      <= S_LOAD;
            cw_in_cnt_q  <= '0;
            cw_out_cnt_q <= '0;
            bit_cnt_q    <= '0;
            to_cnt_q     <= '0;
            err_q        <= ERR_NONE;
          end
        end
        S_LOAD: begin
          if (cw_in_cnt_d == CNT_W'(PREFILL)) begin
            state_q     <= S_RUN;
            dec_start_q <= 1'b1;
            to_cnt_q    <= '0;
          end
        end
        S_RUN: begin
          if (bit_take) begin
            shreg_q   <= word_d[MSG_W-2:0];
            bit_cnt_q <= bit_cnt_d;
          end
          if (word_done) begin
            out_data_q   <= word_d;
            out_valid_q  <= 1'b1;
            cw_out_cnt_q <= final_cnt_d;
          end
          // End-of-message check wins over a timeout landing on the same cycle.
          if (dec_msg_done) begin
            if ((final_cnt_d == CNT_W'(NUM_CW)) && (bit_cnt_d == '0)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q      <= S_ERR;
              err_q        <= ERR_COUNT;
              fifo_flush_q <= 1'b1;
            end
          end else if (bit_take) begin
            to_cnt_q <= '0;
          end else if (to_hit) begin
            state_q      <= S_ERR;
            err_q        <= ERR_TIMEOUT;
            fifo_flush_q <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cw_decoder_ctrl.sv
// Scoreboard bench for cw_decoder_ctrl: expected FIFO writes and message words are
// queued at stimulus time and popped by an independent monitor.
module tb_cw_decoder_ctrl;
  localparam int CW_W = 18, MSG_W = 9, NUM_CW = 10, PREFILL = 2, TO_CYC = 15;

  logic clk = 1'b0;
  logic rst, go, host_valid, fifo_full, dec_bin_msg, dec_msg_rdy, dec_msg_done;
  logic [CW_W-1:0] host_cw, fifo_din;
  logic host_ready, fifo_wr_en, fifo_flush, dec_start, out_valid, busy, done;
  logic [MSG_W-1:0] out_data;
  logic [1:0] err;

  cw_decoder_ctrl #(.CW_W(CW_W), .MSG_W(MSG_W), .NUM_CW(NUM_CW), .PREFILL(PREFILL),
                    .TO_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst), .go(go), .host_valid(host_valid), .host_cw(host_cw),
    .host_ready(host_ready), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
    .fifo_full(fifo_full), .fifo_flush(fifo_flush), .dec_start(dec_start),
    .dec_bin_msg(dec_bin_msg), .dec_msg_rdy(dec_msg_rdy), .dec_msg_done(dec_msg_done),
    .out_valid(out_valid), .out_data(out_data), .busy(busy), .done(done), .err(err));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  logic [CW_W-1:0]  exp_cw[$];
  logic [MSG_W-1:0] exp_w[$];
  int wr_cnt, wr2_cyc, dstart_cyc, dstart_cnt, done_cnt, done_cyc, flush_cnt, valid_cyc;
  int n_words, first_word_seen;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  always @(posedge clk) cyc++;

  // Monitor: compares everything the DUT presents against the queued expectations.
  always @(negedge clk) begin
    if (fifo_wr_en) begin
      wr_cnt++;
      if (wr_cnt == 2) wr2_cyc = cyc;
      if (exp_cw.size() == 0) check("unexpected_fifo_write", 1, 0);
      else check("fifo_din", int'(fifo_din), int'(exp_cw.pop_front()));
    end
    if (dec_start) begin
      dstart_cnt++;
      dstart_cyc = cyc;
    end
    if (out_valid) begin
      valid_cyc = cyc;
      if (n_words == 0) first_word_seen = int'(out_data);
      n_words++;
      if (exp_w.size() == 0) check("unexpected_out_valid", 1, 0);
      else check("out_data", int'(out_data), int'(exp_w.pop_front()));
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (fifo_flush) flush_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic start_msg();
    wr_cnt = 0; wr2_cyc = -100; dstart_cyc = -1; dstart_cnt = 0; done_cnt = 0;
    done_cyc = -1; flush_cnt = 0; valid_cyc = -1; n_words = 0; first_word_seen = -1;
  endtask

  // Offers n codewords; after hold_after accepted words the FIFO reports full for 5 cycles.
  task automatic host_send(input int n, input int hold_after);
    logic acc;
    int waitc;
    for (int i = 0; i < n; i++) begin
      host_cw = CW_W'($urandom);
      host_valid = 1'b1;
      exp_cw.push_back(host_cw);
      waitc = 0;
      do begin
        @(negedge clk);
        acc = host_ready;
        tick();
        waitc++;
      end while (!acc && waitc < 300);
      if (!acc) begin
        check("host_accept_timeout", 0, 1);
        host_valid = 1'b0;
        void'(exp_cw.pop_back());
        return;
      end
      if (i + 1 == hold_after) begin
        fifo_full = 1'b1;
        host_cw = CW_W'($urandom);
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("host_ready_while_full", int'(host_ready), 0);
          check("wr_en_while_full", int'(fifo_wr_en), 0);
          tick();
        end
        check("writes_held_while_full", wr_cnt, hold_after);
        fifo_full = 1'b0;
      end
    end
    if (n == NUM_CW) begin
      host_cw = CW_W'($urandom);
      @(negedge clk);
      check("host_ready_after_all_cw", int'(host_ready), 0);
      tick();
    end
    host_valid = 1'b0;
  endtask

  // mode 0: done one cycle after last bit; 1: done with last bit; 2: never signal done.
  task automatic dec_stream(input int nbits, input bit use_first,
                            input logic [MSG_W-1:0] first_word, input int mode);
    logic bits[$];
    int w;
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (dec_start) break;
      dec_msg_rdy = 1'($urandom);
      dec_bin_msg = 1'($urandom);
      tick();
      dec_msg_rdy = 1'b0;
    end
    if (k == 300) begin
      check("dec_start_timeout", 0, 1);
      return;
    end
    tick();
    for (int i = 0; i < nbits; i++) begin
      if (use_first && i < MSG_W) bits.push_back(first_word[MSG_W-1-i]);
      else bits.push_back(1'($urandom));
    end
    for (int g = 0; g < nbits / MSG_W; g++) begin
      w = 0;
      for (int j = 0; j < MSG_W; j++)
        if (bits[g*MSG_W+j]) w = w + (1 << (MSG_W - 1 - j));
      exp_w.push_back(MSG_W'(w));
    end
    for (int i = 0; i < nbits; i++) begin
      dec_msg_rdy = 1'b1;
      dec_bin_msg = bits[i];
      if (i == nbits - 1 && mode == 1) dec_msg_done = 1'b1;
      tick();
      dec_msg_rdy = 1'b0;
      dec_msg_done = 1'b0;
      if (i != nbits - 1) repeat ($urandom_range(0, 3)) tick();
    end
    if (mode == 0) begin
      tick();
      dec_msg_done = 1'b1;
      tick();
      dec_msg_done = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; go = 1'b0; host_valid = 1'b0; host_cw = '0; fifo_full = 1'b0;
    dec_bin_msg = 1'b0; dec_msg_rdy = 1'b0; dec_msg_done = 1'b0;
    start_msg();
    repeat (2) tick();
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_err", int'(err), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_dec_start", int'(dec_start), 0);
    check("rst_done", int'(done), 0);
    check("rst_fifo_flush", int'(fifo_flush), 0);
    check("rst_host_ready", int'(host_ready), 0);
    tick();
    rst = 1'b0;
    tick();

    // Nominal message with flow control, LOAD-time decoder noise and a stray go in RUN
    start_msg();
    pulse_go();
    fork
      host_send(NUM_CW, 3);
      dec_stream(NUM_CW * MSG_W, 1'b0, '0, 0);
      begin
        for (int k = 0; k < 300 && dstart_cnt == 0; k++) tick();
        repeat (20) tick();
        pulse_go();
      end
    join
    repeat (3) tick();
    check("dec_start_after_2nd_write", dstart_cyc, wr2_cyc + 1);
    check("dec_start_once", dstart_cnt, 1);
    check("nominal_done_once", done_cnt, 1);
    check("nominal_err", int'(err), 0);
    check("nominal_busy_after_done", int'(busy), 0);
    check("nominal_words_left", exp_w.size(), 0);
    check("nominal_word_count", n_words, NUM_CW);
    check("nominal_cw_left", exp_cw.size(), 0);
    check("nominal_writes", wr_cnt, NUM_CW);
    check("nominal_done_not_early", int'(done_cyc >= valid_cyc), 1);

    // Timeout: decoder stalls mid-word
    start_msg();
    pulse_go();
    fork
      host_send(PREFILL, 0);
      dec_stream(4, 1'b0, '0, 2);
    join
    repeat (TO_CYC - 1) tick();
    @(negedge clk);
    check("err_before_timeout", int'(err), 0);
    tick();
    @(negedge clk);
    check("err_timeout", int'(err), 1);
    check("flush_on_timeout", int'(fifo_flush), 1);
    check("busy_in_err", int'(busy), 1);
    tick();
    @(negedge clk);
    check("flush_single_cycle", int'(fifo_flush), 0);
    repeat (4) tick();
    check("err_timeout_sticky", int'(err), 1);
    check("timeout_flush_count", flush_cnt, 1);
    pulse_go();
    @(negedge clk);
    check("go_clears_err", int'(err), 0);
    check("go_from_err_enters_load", int'(host_ready), 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Count mismatch: done after only NUM_CW-1 words
    start_msg();
    pulse_go();
    fork
      host_send(NUM_CW, 0);
      dec_stream((NUM_CW - 1) * MSG_W, 1'b0, '0, 0);
    join
    repeat (3) tick();
    check("mismatch_err", int'(err), 2);
    check("mismatch_no_done", done_cnt, 0);
    check("mismatch_flush_count", flush_cnt, 1);
    check("mismatch_words_left", exp_w.size(), 0);

    // From ERR: done coincides with the last bit; first word forced to 9'h101
    start_msg();
    pulse_go();
    check("go2_clears_err", int'(err), 0);
    fork
      host_send(NUM_CW, 0);
      dec_stream(NUM_CW * MSG_W, 1'b1, 9'h101, 1);
    join
    repeat (3) tick();
    check("sameedge_done_once", done_cnt, 1);
    check("sameedge_err", int'(err), 0);
    check("sameedge_word_count", n_words, NUM_CW);
    check("sameedge_words_left", exp_w.size(), 0);
    check("sameedge_done_not_early", int'(done_cyc >= valid_cyc), 1);
    check("bit_order_first_word", first_word_seen, 'h101);
    check("sameedge_no_flush", flush_cnt, 0);
    check("sameedge_busy", int'(busy), 0);

    // Reset in the middle of RUN
    start_msg();
    pulse_go();
    fork
      host_send(NUM_CW, 0);
      dec_stream(MSG_W + 4, 1'b0, '0, 2);
    join
    check("midrun_busy_before_rst", int'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrun_rst_busy", int'(busy), 0);
    check("midrun_rst_out_valid", int'(out_valid), 0);
    check("midrun_rst_dec_start", int'(dec_start), 0);
    check("midrun_rst_err", int'(err), 0);
    check("midrun_rst_host_ready", int'(host_ready), 0);
    check("midrun_rst_out_data", int'(out_data), 0);
    tick();
    check("midrun_words_done", n_words, 1);
    check("midrun_no_flush", flush_cnt, 0);
    check("midrun_words_left", exp_w.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cw_decoder_ctrl.md
Name: cw_decoder_ctrl

Overview:
Sequencing controller for the constant-weight decoder: `fifo_18_to_18` followed by `decoder_main`. It admits host codewords into the input FIFO under flow control and issues the decoder start pulse after a prefill threshold. It deserializes the decoder's 1-bit message stream into MSG_W-bit words and checks the codeword count per message. It reports done, timeout and count-mismatch errors.

Parameters:
CW_W, 18, codeword width
MSG_W, 9, message bits produced per decoded codeword
NUM_CW, 10, codewords per message
PREFILL, 2, codewords written to FIFO before dec_start (1..NUM_CW)
TO_CYC, 1023, max idle cycles between decoder bits in RUN before timeout

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
go  in  1  pulse: begin one message (accepted in IDLE or ERR only)
host_valid  in  1  host codeword valid
host_cw  in  CW_W  host codeword
host_ready  out  1  controller accepts host_cw this cycle
fifo_wr_en  out  1  FIFO write strobe
fifo_din  out  CW_W  FIFO write data
fifo_full  in  1  FIFO full flag
fifo_flush  out  1  FIFO/decoder reset request
dec_start  out  1  decoder start pulse
dec_bin_msg  in  1  decoder serial message bit
dec_msg_rdy  in  1  qualifies dec_bin_msg (one valid bit per high cycle)
dec_msg_done  in  1  decoder finished all codewords
out_valid  out  1  one-cycle pulse, out_data valid
out_data  out  MSG_W  deserialized message word
busy  out  1  state != IDLE
done  out  1  one-cycle pulse, message completed cleanly
err  out  2  00 none, 01 timeout, 10 count mismatch; sticky

Behaviour:
- Reset (rst=1 at posedge) forces state IDLE and clears all counters. Registered outputs reset to: dec_start=0, fifo_flush=0, out_valid=0, out_data=0, done=0, err=00. Combinational outputs: host_ready=0, fifo_wr_en=0. Reset mid-operation abandons the message; no flush pulse is issued.
- States: IDLE, LOAD, RUN, DONE, ERR.
- IDLE: go -> LOAD. Clear cw_in_cnt, cw_out_cnt, bit_cnt, timeout counter and err.
- host_ready = (state is LOAD or RUN) & !fifo_full & (cw_in_cnt < NUM_CW). This is combinational.
- fifo_wr_en = host_valid & host_ready. fifo_din = host_cw as a pass-through. Each write increments cw_in_cnt.
- LOAD -> RUN on the cycle cw_in_cnt reaches PREFILL, counting the write made in that cycle. dec_start is registered and high for exactly the first RUN cycle.
- RUN continues accepting host words until cw_in_cnt = NUM_CW.
- Deserializer: on each dec_msg_rdy, shift dec_bin_msg in. The first bit lands in the out_data MSB. bit_cnt increments.
- When bit_cnt reaches MSG_W, the next cycle has out_valid=1 and holds the word. Then bit_cnt is cleared and cw_out_cnt is incremented. out_data holds its value until the next word.
- The timeout counter clears on each dec_msg_rdy and on entry to RUN, and increments otherwise. When it equals TO_CYC -> ERR with err=01.
- dec_msg_done in RUN is checked against final_cnt = cw_out_cnt, plus 1 if a word completes on that same cycle, with bit_cnt = 0 after that completion.
  - If final_cnt = NUM_CW and bit_cnt = 0 -> DONE. A word completing on the same cycle is still emitted via out_valid.
  - Otherwise -> ERR with err=10.
- DONE: done=1 for one cycle, then IDLE.
- ERR: on entry, fifo_flush=1 for one cycle; host_ready=0. err is held. go -> clears err, then LOAD.
- Inputs are ignored outside their states: dec_msg_rdy and dec_msg_done in IDLE, LOAD, DONE and ERR; go in LOAD, RUN and DONE.
- When fifo_full and host_valid coincide, no write occurs and cw_in_cnt is held.
- Timeout and dec_msg_done in the same cycle: dec_msg_done has priority.

Test Plan:
- Nominal: go, 10 codewords back-to-back, decoder bits 9 per codeword -> dec_start at cycle after 2nd write; 10 out_valid pulses carry the expected 9-bit values; done pulses once; err=00; busy drops after DONE.
- Flow control: hold fifo_full=1 after 3 writes for 5 cycles -> host_ready=0 and no fifo_wr_en in those cycles; cw_in_cnt stays 3; transfer resumes with no lost or duplicated codeword.
- Bit order: stream 1,0,0,0,0,0,0,0,1 with dec_msg_rdy gaps of 0–3 cycles -> out_data=9'h101, out_valid exactly once.
- Timeout: TO_CYC=15, stop dec_msg_rdy mid-word -> ERR with err=01 on the 15th idle cycle; fifo_flush pulses once; a following go clears err and enters LOAD.
- Mismatch: dec_msg_done after 9 words -> err=10, no done pulse. Separately, done on the same cycle as the 10th word's last bit -> 10th out_valid, then done, err=00.
- Reset mid-RUN: rst=1 for 1 cycle -> next cycle state IDLE; busy=0, out_valid=0, dec_start=0, err=00.
